uart_tx: RTL

Baud-tick-driven UART serializer for the UART datapath. It sits directly downstream of the start-pulse conditioner, which delivers a start request qualified by `baud_clk_posedge`. On that request it latches a parallel byte and shifts out a standard asynchronous frame on `tx`: start bit, data LSB-first, optional parity, then stop bit(s). It advances exactly one bit per baud tick and reports `busy` and a one-cycle `done`.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line levels and default frame shape.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    localparam int UART_DEFAULT_DATA_BITS = 8;
    localparam int UART_DEFAULT_STOP_BITS = 1;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_TX_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// Baud-tick-driven UART serializer: start bit, LSB-first data, optional even parity, stop bit(s).
// Define UART_TX_PARITY_EN to insert the even-parity bit between data and stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DEFAULT_DATA_BITS,
    parameter int STOP_BITS = UART_DEFAULT_STOP_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_clk_posedge,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    uart_tx_state_t       state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    // tx is registered, so each tick loads the level for the coming bit period
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        if (baud_clk_posedge) begin
            case (state_q)
                TX_IDLE: begin
                    if (start) begin
                        state_d    = TX_START;
                        shreg_d    = data;
                        bit_cnt_d  = '0;
                        stop_cnt_d = 1'b0;
                        tx_d       = UART_START_LEVEL;
                        busy_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
                        parity_d   = ^data;
`endif
                    end
                end
                TX_START: begin
                    state_d = TX_DATA;
                    tx_d    = shreg_q[0];
                end
                TX_DATA: begin
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = TX_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = TX_STOP;
                        tx_d    = UART_IDLE_LEVEL;
`endif
                    end else begin
                        tx_d = shreg_q[1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                TX_PARITY: begin
                    state_d = TX_STOP;
                    tx_d    = UART_IDLE_LEVEL;
                end
`endif
                TX_STOP: begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = TX_IDLE;
                        tx_d    = UART_IDLE_LEVEL;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = TX_IDLE;
                    tx_d    = UART_IDLE_LEVEL;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= TX_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= UART_IDLE_LEVEL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
